// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, control-bit indices and slot operations for the pipeline stage registers
// Contents:
//   *_CTRL_W / *_<FIELD>  control-bundle width and bit index per stage boundary
//   NOP_CTRL              control value presented by every empty slot
//   slot_op_e             per-cycle operation applied to one pipe_slot
package pipe_pkg;

  // IF/ID carries no real control yet; one bit keeps the port width legal.
  localparam int IFID_CTRL_W     = 1;
  localparam int IFID_PRED_TAKEN = 0;

  localparam int IDEX_CTRL_W     = 9;
  localparam int IDEX_REGWRITE   = 0;
  localparam int IDEX_MEMTOREG   = 1;
  localparam int IDEX_MEMREAD    = 2;
  localparam int IDEX_MEMWRITE   = 3;
  localparam int IDEX_BRANCH     = 4;
  localparam int IDEX_ALUSRC     = 5;
  localparam int IDEX_REGDST     = 6;
  localparam int IDEX_ALUOP_LO   = 7;
  localparam int IDEX_ALUOP_HI   = 8;

  localparam int EXMEM_CTRL_W    = 5;
  localparam int EXMEM_REGWRITE  = 0;
  localparam int EXMEM_MEMTOREG  = 1;
  localparam int EXMEM_MEMREAD   = 2;
  localparam int EXMEM_MEMWRITE  = 3;
  localparam int EXMEM_BRANCH    = 4;

  localparam int MEMWB_CTRL_W    = 2;
  localparam int MEMWB_REGWRITE  = 0;
  localparam int MEMWB_MEMTOREG  = 1;

  // Widest control bundle any boundary may use; a bubble is all zeros.
  localparam int MAX_CTRL_W = 16;
  localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = '0;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,  // keep contents
    SLOT_LOAD  = 2'd1,  // capture a new beat, becomes valid
    SLOT_EMPTY = 2'd2,  // beat left downstream, data kept
    SLOT_FLUSH = 2'd3   // beat killed, data optionally cleared
  } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid + control + data register entry of a pipeline stage
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   op_i              hold / load / empty / flush for this cycle
//   ctrl_i, data_i    beat captured on load
//   valid_o           entry occupied
//   ctrl_o, data_o    stored beat; ctrl_o is NOP_CTRL whenever valid_o = 0
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 2,
  parameter int DATA_W   = 96,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  slot_op_e          op_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Control is zeroed whenever the slot goes empty so a bubble can never
  // write a register or touch memory; data only matters while valid.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    case (op_i)
      SLOT_LOAD: begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_i;
        data_d  = data_i;
      end
      SLOT_EMPTY: begin
        valid_d = 1'b0;
        ctrl_d  = NOP_CTRL[CTRL_W-1:0];
      end
      SLOT_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = NOP_CTRL[CTRL_W-1:0];
        if (CLR_DATA) data_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL[CTRL_W-1:0];
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - elastic inter-stage pipeline register with flush and optional skid entry
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   valid_i, ready_o           upstream handshake
//   ctrl_i, data_i             upstream control / data bundle
//   valid_o, ready_i           downstream handshake
//   ctrl_o, data_o             head entry; ctrl_o all zero while valid_o = 0
//   flush_i                    kill held and incoming beats
//   count_o                    occupied entries (0..2)
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 2,
  parameter int DATA_W   = 96,
  parameter bit SKID_EN  = 1'b1,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  output logic [1:0]        count_o
);

  logic              head_v;
  logic [CTRL_W-1:0] head_c;
  logic [DATA_W-1:0] head_d;
  logic [CTRL_W-1:0] head_ctrl_in;
  logic [DATA_W-1:0] head_data_in;
  slot_op_e          head_op;
  logic              accept;
  logic              drain;

  assign accept = valid_i & ready_o;
  assign drain  = head_v & ready_i;

  pipe_slot #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CLR_DATA (CLR_DATA)
  ) u_head (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .op_i    (head_op),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_v),
    .ctrl_o  (head_c),
    .data_o  (head_d)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic              skid_v;
      logic [CTRL_W-1:0] skid_c;
      logic [DATA_W-1:0] skid_d;
      slot_op_e          skid_op;

      pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
      ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op_i    (skid_op),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .valid_o (skid_v),
        .ctrl_o  (skid_c),
        .data_o  (skid_d)
      );

      // Upstream sees only the skid flop, so ready_i never reaches ready_o
      // combinationally; the skid absorbs the one beat already in flight.
      assign ready_o = ~skid_v;

      // The head only ever refills from the skid when the skid holds the
      // older beat; otherwise it takes the incoming beat.
      assign head_ctrl_in = skid_v ? skid_c : ctrl_i;
      assign head_data_in = skid_v ? skid_d : data_i;

      always_comb begin
        head_op = SLOT_HOLD;
        skid_op = SLOT_HOLD;
        if (flush_i) begin
          head_op = SLOT_FLUSH;
          skid_op = SLOT_FLUSH;
        end else if (drain) begin
          if (skid_v) begin
            head_op = SLOT_LOAD;
            skid_op = accept ? SLOT_LOAD : SLOT_EMPTY;
          end else begin
            head_op = accept ? SLOT_LOAD : SLOT_EMPTY;
          end
        end else if (accept) begin
          if (head_v) skid_op = SLOT_LOAD;
          else        head_op = SLOT_LOAD;
        end
      end

      assign count_o = {1'b0, head_v} + {1'b0, skid_v};
    end else begin : g_single
      // Combinational ready_i -> ready_o path: the upstream stage's timing
      // budget must include this stage's ready logic.
      assign ready_o = ~head_v | ready_i;

      assign head_ctrl_in = ctrl_i;
      assign head_data_in = data_i;

      always_comb begin
        head_op = SLOT_HOLD;
        if (flush_i)     head_op = SLOT_FLUSH;
        else if (accept) head_op = SLOT_LOAD;
        else if (drain)  head_op = SLOT_EMPTY;
      end

      assign count_o = {1'b0, head_v};
    end
  endgenerate

  assign valid_o = head_v;
  assign ctrl_o  = head_c;
  assign data_o  = head_d;

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - self-checking bench for pipe_stage in skid and single-entry configurations
module tb_pipe_stage;
  import pipe_pkg::*;

  localparam int CW = MEMWB_CTRL_W;
  localparam int DW = 96;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i, ready_i, flush_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          s_valid_o, s_ready_o, n_valid_o, n_ready_o;
  logic [CW-1:0] s_ctrl_o, n_ctrl_o;
  logic [DW-1:0] s_data_o, n_data_o;
  logic [1:0]    s_count_o, n_count_o;

  always #5 clk_i = ~clk_i;

  pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CLR_DATA(1'b0)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(s_ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(s_valid_o), .ready_i(ready_i),
    .ctrl_o(s_ctrl_o), .data_o(s_data_o), .flush_i(flush_i), .count_o(s_count_o)
  );

  pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .CLR_DATA(1'b0)) u_single (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(n_ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(n_valid_o), .ready_i(ready_i),
    .ctrl_o(n_ctrl_o), .data_o(n_data_o), .flush_i(flush_i), .count_o(n_count_o)
  );

  int checks = 0;
  int failures = 0;
  logic [CW+DW-1:0] q0[$];  // expected beats, skid instance
  logic [CW+DW-1:0] q1[$];  // expected beats, single-entry instance

  typedef struct {
    logic          v;
    logic          r;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] ed;
    logic [1:0]    ecnt;
    logic          er;
    logic          enr;
  } vec_t;
  vec_t tbl[8];

  function automatic vec_t mk(logic v, logic r, logic [DW-1:0] d, logic ev, logic [DW-1:0] ed,
                              logic [1:0] ecnt, logic er, logic enr);
    vec_t x;
    x.v = v; x.r = r; x.d = d; x.ev = ev; x.ed = ed; x.ecnt = ecnt; x.er = er; x.enr = enr;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic score(input bit k);
    logic             vo, ro;
    logic [CW+DW-1:0] got, want;
    string            tag;
    int               sz;
    tag = k ? "single" : "skid";
    vo  = k ? n_valid_o : s_valid_o;
    ro  = k ? n_ready_o : s_ready_o;
    got = k ? {n_ctrl_o, n_data_o} : {s_ctrl_o, s_data_o};
    sz  = k ? q1.size() : q0.size();
    if (!vo) chk({tag, "_nop_ctrl"}, 128'(got[CW+DW-1:DW]), 128'(0));
    if (vo && ready_i) begin
      if (sz == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_beat got=%0h want=none", tag, got);
      end else begin
        want = k ? q1.pop_front() : q0.pop_front();
        chk({tag, "_order"}, 128'(got), 128'(want));
      end
    end
    if (flush_i) begin
      if (k) q1.delete(); else q0.delete();
    end else if (valid_i && ro) begin
      if (k) q1.push_back({ctrl_i, data_i}); else q0.push_back({ctrl_i, data_i});
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
    if (rst_i) begin
      score(1'b0);
      score(1'b1);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    ctrl_i = '0; data_i = '0;
    repeat (3) adv();
    chk("rst_valid", 128'(s_valid_o), 128'(0));
    chk("rst_ctrl",  128'(s_ctrl_o),  128'(0));
    chk("rst_data",  128'(s_data_o),  128'(0));
    chk("rst_count", 128'(s_count_o), 128'(0));
    chk("rst_ready", 128'(s_ready_o), 128'(1));
    rst_i = 1'b1;

    // Constant stream, downstream always ready.
    valid_i = 1'b1; ctrl_i = 2'b11; data_i = 96'h1234; ready_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("t1_valid",   128'(s_valid_o), 128'(i >= 1));
      chk("t1_count",   128'(s_count_o), 128'(i >= 1));
      chk("t1_n_count", 128'(n_count_o), 128'(i >= 1));
      chk("t1_ready",   128'(s_ready_o), 128'(1));
      if (i >= 1) begin
        chk("t1_ctrl", 128'(s_ctrl_o), 128'(2'b11));
        chk("t1_data", 128'(s_data_o), 128'(96'h1234));
      end
      adv();
    end
    idle(3);

    // Three-cycle stall with the skid entry absorbing the in-flight beat.
    tbl[0] = mk(1, 1, 96'h1, 0, 96'h0, 2'd0, 1, 1);
    tbl[1] = mk(1, 0, 96'h2, 1, 96'h1, 2'd1, 1, 0);
    tbl[2] = mk(1, 0, 96'h3, 1, 96'h1, 2'd2, 0, 0);
    tbl[3] = mk(1, 0, 96'h3, 1, 96'h1, 2'd2, 0, 0);
    tbl[4] = mk(1, 1, 96'h3, 1, 96'h1, 2'd2, 0, 1);
    tbl[5] = mk(1, 1, 96'h3, 1, 96'h2, 2'd1, 1, 1);
    tbl[6] = mk(0, 1, 96'h0, 1, 96'h3, 2'd1, 1, 1);
    tbl[7] = mk(0, 1, 96'h0, 0, 96'h0, 2'd0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      valid_i = tbl[i].v; ready_i = tbl[i].r; data_i = tbl[i].d;
      ctrl_i  = tbl[i].v ? 2'b11 : 2'b00;
      sample();
      chk("tbl_valid",   128'(s_valid_o), 128'(tbl[i].ev));
      chk("tbl_count",   128'(s_count_o), 128'(tbl[i].ecnt));
      chk("tbl_ready",   128'(s_ready_o), 128'(tbl[i].er));
      chk("tbl_n_ready", 128'(n_ready_o), 128'(tbl[i].enr));
      chk("tbl_ctrl",    128'(s_ctrl_o),  128'(tbl[i].ev ? 2'b11 : 2'b00));
      if (tbl[i].ev) chk("tbl_data", 128'(s_data_o), 128'(tbl[i].ed));
      adv();
    end
    idle(2);

    // Flush with two entries held and a beat offered in the flush cycle.
    ctrl_i = 2'b01; ready_i = 1'b0; valid_i = 1'b1;
    data_i = 96'hA; sample(); adv();
    data_i = 96'hB; sample(); adv();
    data_i = 96'hC; flush_i = 1'b1;
    sample();
    chk("fl_count_before", 128'(s_count_o), 128'(2));
    adv();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    sample();
    chk("fl_valid",   128'(s_valid_o), 128'(0));
    chk("fl_ctrl",    128'(s_ctrl_o),  128'(0));
    chk("fl_count",   128'(s_count_o), 128'(0));
    chk("fl_ready",   128'(s_ready_o), 128'(1));
    chk("fl_n_valid", 128'(n_valid_o), 128'(0));
    chk("fl_n_count", 128'(n_count_o), 128'(0));
    adv();
    valid_i = 1'b1; data_i = 96'hD; ctrl_i = 2'b10;
    sample(); adv();
    valid_i = 1'b0;
    sample();
    chk("fl_next_data", 128'(s_data_o), 128'(96'hD));
    adv();
    idle(2);

    // Asynchronous reset between clock edges with entries held.
    valid_i = 1'b1; ready_i = 1'b0; ctrl_i = 2'b11; data_i = 96'hE;
    sample(); adv();
    sample(); adv();
    #2 rst_i = 1'b0;
    #1;
    chk("ar_valid",   128'(s_valid_o), 128'(0));
    chk("ar_ctrl",    128'(s_ctrl_o),  128'(0));
    chk("ar_data",    128'(s_data_o),  128'(0));
    chk("ar_count",   128'(s_count_o), 128'(0));
    chk("ar_ready",   128'(s_ready_o), 128'(1));
    chk("ar_n_valid", 128'(n_valid_o), 128'(0));
    q0.delete(); q1.delete();
    valid_i = 1'b0;
    adv();
    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 96'hF; ctrl_i = 2'b01;
    sample();
    chk("ar_post_valid0", 128'(s_valid_o), 128'(0));
    adv();
    valid_i = 1'b0;
    sample();
    chk("ar_post_valid1", 128'(s_valid_o), 128'(1));
    chk("ar_post_data",   128'(s_data_o),  128'(96'hF));
    adv();
    idle(2);

    // Random handshakes with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      flush_i = ($urandom_range(0, 63) == 0);
      ctrl_i  = 2'($urandom);
      data_i  = {$urandom, $urandom, $urandom};
      sample();
      adv();
    end
    idle(4);
    chk("end_q_skid",   128'(q0.size()), 128'(0));
    chk("end_q_single", 128'(q1.size()), 128'(0));
    chk("end_count",    128'(s_count_o), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
